// File: rtl/async_fifo_pkg.sv
// Shared definitions for the dual-clock FIFO write- and read-side controllers:
// controller state enum, synchronizer depth and Gray/binary conversion helpers.
// Build option: define ASYNC_FIFO_WR_SYNC3_EN for a three-flop pointer
// synchronizer (longer INIT, one extra edge of read-release latency).
package async_fifo_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } wr_state_e;

`ifdef ASYNC_FIFO_WR_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    // Helpers work on a 32-bit container; callers size-cast to the pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/async_fifo_wr_ctrl_if.sv
// Write-side controller bus: producer request, RAM write port, pointer
// exchange with the read domain and status flags.
// master = producer/environment side, slave = write controller.
interface async_fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  WrReq_in;
    logic                  WrEn_out;
    logic [ADDR_WIDTH-1:0] WrAddr_out;
    logic [ADDR_WIDTH:0]   WrPtrGray_out;
    logic [ADDR_WIDTH:0]   RdPtrGray_in;
    logic                  Full_out;
    logic                  AlmostFull_out;
    logic [ADDR_WIDTH:0]   Level_out;
    logic                  Overflow_out;

    modport master (
        output WrReq_in,
        output RdPtrGray_in,
        input  WrEn_out,
        input  WrAddr_out,
        input  WrPtrGray_out,
        input  Full_out,
        input  AlmostFull_out,
        input  Level_out,
        input  Overflow_out
    );

    modport slave (
        input  WrReq_in,
        input  RdPtrGray_in,
        output WrEn_out,
        output WrAddr_out,
        output WrPtrGray_out,
        output Full_out,
        output AlmostFull_out,
        output Level_out,
        output Overflow_out
    );
endinterface

// File: rtl/gray_ptr_sync.sv
// Plain flop-chain synchronizer for a Gray-coded pointer crossing clock
// domains. Only one bit changes per source update, so every stage holds
// either the old or the new pointer value.
module gray_ptr_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift the incoming pointer through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/async_fifo_wr_ctrl.sv
// Write-side pointer and flag controller of the dual-clock FIFO. Owns the
// Gray write pointer, synchronizes the read Gray pointer and derives
// Full / AlmostFull / Level / sticky Overflow, all in the write clock domain.
// Build option: ASYNC_FIFO_WR_SYNC3_EN selects a three-flop synchronizer.
module async_fifo_wr_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 2
) (
    input logic                Clk,
    input logic                Reset_in,
    async_fifo_wr_ctrl_if.slave bus
);
    import async_fifo_pkg::*;

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PTR_W-1:0] AF_LEVEL   = PTR_W'(DEPTH - AF_MARGIN);
    localparam logic [1:0]       INIT_LAST  = 2'(SYNC_STAGES - 1);

    wr_state_e             state_r;
    wr_state_e             state_s;
    logic [1:0]            init_cnt_r;
    logic [1:0]            init_cnt_s;

    logic [PTR_W-1:0]      wr_bin_r;
    logic [PTR_W-1:0]      wr_bin_next_s;
    logic [PTR_W-1:0]      wr_gray_r;
    logic [PTR_W-1:0]      wr_gray_next_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r;

    logic [PTR_W-1:0]      rd_gray_s;
    logic [PTR_W-1:0]      rd_bin_s;
    logic [PTR_W-1:0]      full_gray_s;
    logic [PTR_W-1:0]      level_r;
    logic [PTR_W-1:0]      level_next_s;

    logic                  wr_en_s;
    logic                  full_r;
    logic                  full_next_s;
    logic                  af_r;
    logic                  af_next_s;
    logic                  ovf_r;
    logic                  ovf_next_s;

    gray_ptr_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk (Clk),
        .rst (Reset_in),
        .d   (bus.RdPtrGray_in),
        .q   (rd_gray_s)
    );

    // Write strobe: only in RUN and only while not full.
    always_comb begin
        wr_en_s = bus.WrReq_in & ~full_r & (state_r == RUN);
    end

    // Next-state logic: INIT waits until the synchronizer holds real data.
    always_comb begin
        state_s    = state_r;
        init_cnt_s = init_cnt_r;
        case (state_r)
            INIT: begin
                if (init_cnt_r == INIT_LAST) begin
                    state_s    = RUN;
                    init_cnt_s = 2'd0;
                end else begin
                    state_s    = INIT;
                    init_cnt_s = init_cnt_r + 2'd1;
                end
            end
            RUN: begin
                state_s    = RUN;
                init_cnt_s = 2'd0;
            end
            default: begin
                state_s    = INIT;
                init_cnt_s = 2'd0;
            end
        endcase
    end

    // Pointer advance and flag computation, including this cycle's accept.
    always_comb begin
        wr_bin_next_s  = wr_bin_r;
        wr_gray_next_s = wr_gray_r;
        full_next_s    = 1'b1;
        ovf_next_s     = ovf_r;

        if (wr_en_s) begin
            wr_bin_next_s = wr_bin_r + PTR_W'(1);
        end else begin
            wr_bin_next_s = wr_bin_r;
        end
        wr_gray_next_s = PTR_W'(bin2gray(32'(wr_bin_next_s)));

        rd_bin_s     = PTR_W'(gray2bin(32'(rd_gray_s)));
        // Full when the write pointer is one whole lap ahead of the read pointer.
        full_gray_s  = {~rd_gray_s[PTR_W-1:PTR_W-2], rd_gray_s[PTR_W-3:0]};
        level_next_s = wr_bin_next_s - rd_bin_s;
        af_next_s    = (level_next_s >= AF_LEVEL);

        // Full stays forced until the edge that enters RUN.
        if (state_s == RUN) begin
            full_next_s = (wr_gray_next_s == full_gray_s);
        end else begin
            full_next_s = 1'b1;
        end

        if ((state_r == RUN) && bus.WrReq_in && full_r) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // State, pointer and flag registers.
    always_ff @(posedge Clk) begin
        if (Reset_in) begin
            state_r    <= INIT;
            init_cnt_r <= 2'd0;
            wr_bin_r   <= '0;
            wr_gray_r  <= '0;
            wr_addr_r  <= '0;
            level_r    <= '0;
            full_r     <= 1'b1;
            af_r       <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            init_cnt_r <= init_cnt_s;
            wr_bin_r   <= wr_bin_next_s;
            wr_gray_r  <= wr_gray_next_s;
            wr_addr_r  <= wr_bin_next_s[ADDR_WIDTH-1:0];
            level_r    <= level_next_s;
            full_r     <= full_next_s;
            af_r       <= af_next_s;
            ovf_r      <= ovf_next_s;
        end
    end

    assign bus.WrEn_out       = wr_en_s;
    assign bus.WrAddr_out     = wr_addr_r;
    assign bus.WrPtrGray_out  = wr_gray_r;
    assign bus.Full_out       = full_r;
    assign bus.AlmostFull_out = af_r;
    assign bus.Level_out      = level_r;
    assign bus.Overflow_out   = ovf_r;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Self-checking bench for async_fifo_wr_ctrl (ADDR_WIDTH=4, AF_MARGIN=2).
// A bench-side occupancy model predicts every registered output; predictions
// are queued before each edge and compared after it.
module tb_async_fifo_wr_ctrl;
    import async_fifo_pkg::*;

    typedef struct packed {
        logic [3:0] addr;
        logic [4:0] gray;
        logic       full;
        logic       af;
        logic [4:0] level;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    exp_t       sb[$];
    logic [4:0] rd_q[$];
    logic [4:0] m_wr;
    logic       m_full;
    logic       m_ovf;
    int         m_init;

    async_fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

    async_fifo_wr_ctrl #(
        .ADDR_WIDTH (4),
        .AF_MARGIN  (2)
    ) dut (
        .Clk      (clk),
        .Reset_in (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] g2b(input logic [4:0] g);
        logic [4:0] b;
        b = '0;
        for (int i = 0; i < 5; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    function automatic logic [4:0] b2g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wr   = 5'd0;
        m_full = 1'b1;
        m_ovf  = 1'b0;
        m_init = SYNC_STAGES;
        rd_q   = {};
        for (int i = 0; i < SYNC_STAGES; i++) rd_q.push_back(5'd0);
        sb     = {};
    endtask

    // Synchronous reset edge; request may be active to show it is ignored.
    task automatic do_reset(input logic req);
        @(negedge clk);
        rst = 1'b1;
        bus.WrReq_in = req;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_full",  32'(bus.Full_out),       32'd1);
        chk("rst_level", 32'(bus.Level_out),      32'd0);
        chk("rst_gray",  32'(bus.WrPtrGray_out),  32'd0);
        chk("rst_addr",  32'(bus.WrAddr_out),     32'd0);
        chk("rst_af",    32'(bus.AlmostFull_out), 32'd0);
        chk("rst_ovf",   32'(bus.Overflow_out),   32'd0);
        rst = 1'b0;
    endtask

    // One clock: drive inputs, check strobe, predict and check registered outputs.
    task automatic step(input logic req, input logic [4:0] rdg);
        exp_t       e;
        exp_t       o;
        logic       running;
        logic       acc;
        logic [4:0] nxt;
        logic [4:0] vis;
        logic [4:0] occ;
        @(negedge clk);
        bus.WrReq_in     = req;
        bus.RdPtrGray_in = rdg;
        #1;
        running = (m_init == 0);
        acc     = req && running && !m_full;
        chk("wren", 32'(bus.WrEn_out), 32'(acc));
        nxt = m_wr + (acc ? 5'd1 : 5'd0);
        vis = rd_q.pop_front();
        rd_q.push_back(g2b(rdg));
        occ = nxt - vis;
        e.full  = (m_init > 1) ? 1'b1 : (occ == 5'd16);
        e.level = occ;
        e.af    = (occ >= 5'd14);
        e.gray  = b2g(nxt);
        e.addr  = nxt[3:0];
        m_ovf   = m_ovf | (running && req && m_full);
        e.ovf   = m_ovf;
        sb.push_back(e);
        if (m_init > 0) m_init--;
        m_wr   = nxt;
        m_full = e.full;
        @(posedge clk);
        #1;
        o = sb.pop_front();
        chk("addr",  32'(bus.WrAddr_out),     32'(o.addr));
        chk("gray",  32'(bus.WrPtrGray_out),  32'(o.gray));
        chk("full",  32'(bus.Full_out),       32'(o.full));
        chk("af",    32'(bus.AlmostFull_out), 32'(o.af));
        chk("level", 32'(bus.Level_out),      32'(o.level));
        chk("ovf",   32'(bus.Overflow_out),   32'(o.ovf));
        chk("lvl_ge_occ", 32'(bus.Level_out >= 5'(m_wr - g2b(rdg))), 32'd1);
    endtask

    initial begin
        logic [4:0] prev_gray;
        logic [4:0] rd_bin;
        int         lat;
        n_checks         = 0;
        n_pass           = 0;
        rst              = 1'b1;
        bus.WrReq_in     = 1'b0;
        bus.RdPtrGray_in = 5'd0;
        model_reset();

        // Start-up: request held from cycle 0, INIT blocks the first cycles.
        do_reset(1'b0);
        step(1'b1, 5'd0);
        step(1'b1, 5'd0);
        step(1'b1, 5'd0);
        chk("first_addr", 32'(bus.WrAddr_out), 32'd1);
        chk("first_gray", 32'(bus.WrPtrGray_out), 32'b00001);

        // Fill to full, then overflow.
        for (int i = 1; i < 16; i++) step(1'b1, 5'd0);
        chk("full_gray", 32'(bus.WrPtrGray_out), 32'b11000);
        chk("full_flag", 32'(bus.Full_out), 32'd1);
        chk("full_lvl",  32'(bus.Level_out), 32'd16);
        step(1'b1, 5'd0);
        chk("ovf_set",  32'(bus.Overflow_out), 32'd1);
        chk("ovf_ptr",  32'(bus.WrPtrGray_out), 32'b11000);
        step(1'b0, 5'd0);
        chk("ovf_hold", 32'(bus.Overflow_out), 32'd1);

        // Read release latency after one read.
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 5'd1);
            if (lat == 99 && bus.Full_out == 1'b0) lat = i;
        end
        chk("release_lat", 32'(lat), 32'(SYNC_STAGES + 1));
        chk("release_lvl", 32'(bus.Level_out), 32'd15);

        // Full lap with the reader one step behind.
        do_reset(1'b0);
        step(1'b0, 5'd0);
        step(1'b0, 5'd0);
        prev_gray = 5'd0;
        for (int i = 0; i < 32; i++) begin
            step(1'b1, b2g(m_wr - ((m_wr == 5'd0) ? 5'd0 : 5'd1)));
            chk("hamming", 32'($countones(bus.WrPtrGray_out ^ prev_gray)), 32'd1);
            chk("lap_nofull", 32'(bus.Full_out), 32'd0);
            prev_gray = bus.WrPtrGray_out;
        end
        chk("wrap_zero", 32'(bus.WrPtrGray_out), 32'd0);

        // Reset in the middle of a stream at Level 9.
        do_reset(1'b0);
        for (int i = 0; i < 11; i++) step(1'b1, 5'd0);
        chk("mid_lvl9", 32'(bus.Level_out), 32'd9);
        do_reset(1'b1);
        step(1'b1, 5'd0);
        chk("reinit_noacc", 32'(bus.WrPtrGray_out), 32'd0);

        // Random requests with a legal random read walk.
        do_reset(1'b0);
        rd_bin = 5'd0;
        for (int i = 0; i < 400; i++) begin
            if (rd_bin != m_wr && $urandom_range(0, 99) < 40) rd_bin = rd_bin + 5'd1;
            step(1'($urandom_range(0, 99) < 60), b2g(rd_bin));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Write-side pointer and flag controller for the team's dual-clock FIFOs; lives entirely in the write clock domain.
- Owns the Gray-coded write pointer and brings the read domain's Gray pointer in through a multi-flop synchronizer.
- Produces the RAM write enable/address, Full/AlmostFull/Level flags and a sticky overflow error.
- Pairs with a mirror read-side controller; the two exchange only Gray pointers.

Parameters:
ADDR_WIDTH, 4, RAM address bits; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits (extra wrap bit).
AF_MARGIN, 2, AlmostFull_out asserts when Level_out >= depth - AF_MARGIN; legal range 1..depth-1.

Ports:
Clk  in  1  write-domain clock, all logic on posedge.
Reset_in  in  1  synchronous, active-high reset.
WrReq_in  in  1  producer write request.
WrEn_out  out  1  RAM write strobe; combinational = WrReq_in & ~Full_out & (state==RUN).
WrAddr_out  out  ADDR_WIDTH  RAM write address = low bits of binary write pointer (registered).
WrPtrGray_out  out  ADDR_WIDTH+1  registered Gray write pointer, sent to read domain.
RdPtrGray_in  in  ADDR_WIDTH+1  read domain's Gray pointer, asynchronous to Clk.
Full_out  out  1  FIFO full, registered.
AlmostFull_out  out  1  registered.
Level_out  out  ADDR_WIDTH+1  registered fill estimate, 0..depth.
Overflow_out  out  1  sticky: write requested while full.

Behaviour:
- Reset values: wr_bin=0, WrPtrGray_out=0, WrAddr_out=0, all sync flops=0, Level_out=0, AlmostFull_out=0, Overflow_out=0, Full_out=1; state=INIT.
- Reset mid-operation: the next edge restores every reset value and re-enters INIT. Pointer history is discarded, so the read side must be reset together with this block.
- FSM has two states.
  - INIT: Full_out forced 1, WrEn_out 0. Stays for SYNC_STAGES cycles (2 by default), counted by an internal counter, until the synchronizer holds valid data. Then goes to RUN.
  - RUN: normal operation; left only on reset.
- Accept rule: a write is accepted when WrEn_out=1 at a posedge. On that edge:
  - wr_bin <= wr_bin+1, modulo 2**(ADDR_WIDTH+1).
  - WrPtrGray_out <= bin2gray(wr_bin+1).
  - WrAddr_out <= (wr_bin+1) low bits.
  - The RAM writes at the current WrAddr_out on the same edge.
- Synchronizer: RdPtrGray_in passes through SYNC_STAGES flops. rd_bin_s = gray2bin(last stage), computed combinationally.
- Full_out (RUN) <= (next_wr_gray == {~rd_gray_s[MSB:MSB-1], rd_gray_s[MSB-2:0]}), where next_wr_gray includes this cycle's accept. Full asserts on the edge that accepts the depth-th word (zero-cycle slip).
- Level_out <= (next_wr_bin - rd_bin_s) mod 2**(ADDR_WIDTH+1).
- AlmostFull_out <= Level_next >= depth - AF_MARGIN.
- Read-side release is pessimistic: an RdPtrGray_in change reaches Full/Level/AlmostFull exactly SYNC_STAGES+1 edges later. Full is never early.
- Simultaneous accept and read-pointer advance: both are applied in the same flag computation.
- WrReq_in while Full_out=1 in RUN:
  - no RAM write, pointer unchanged;
  - Overflow_out <= 1 and holds until reset.
- WrReq_in during INIT is ignored and does not set Overflow_out.
- Wrap-around: after 2**(ADDR_WIDTH+1) accepts the pointer returns to 0. Gray output changes exactly one bit per accept, including at wrap.

Optional Feature:
ASYNC_FIFO_WR_SYNC3_EN
- Defined: SYNC_STAGES=3 (three-flop synchronizer); INIT lasts 3 cycles; read-release latency is 4 edges.
- Undefined: SYNC_STAGES=2; INIT lasts 2 cycles; release latency is 3 edges.
- No port or parameter change either way.

Decomposition:
- Shared package async_fifo_pkg: state enum {INIT, RUN}, SYNC_STAGES constant (macro-selected), bin2gray/gray2bin functions. The read-side controller reuses this package.
- One sub-module: gray_ptr_sync (WIDTH, STAGES), a pure flop-chain synchronizer, instantiated once here and once on the read side.

Test Plan:
- Reset, then WrReq_in=1 from cycle 0: Full_out=1 and WrEn_out=0 for 2 cycles; first accept on cycle 2; WrAddr_out=1 and WrPtrGray_out=5'b00001 after that edge.
- RdPtrGray_in=0, 16 consecutive accepts:
  - AlmostFull_out rises on the 14th accept edge (Level=14);
  - Full_out rises on the 16th (Level=16, WrPtrGray_out=5'b11000);
  - 17th request gives no WrEn_out, pointer unchanged, Overflow_out=1 and stays 1.
- Full, then RdPtrGray_in stepped 0->1: Full_out=0 and Level_out=15 exactly 3 edges later (4 with ASYNC_FIFO_WR_SYNC3_EN).
- 32 accepts with RdPtrGray_in tracking one step behind (read side emulated): WrPtrGray_out Hamming distance is 1 per accept; pointer returns to 0 at wrap; Full_out never asserts.
- Reset_in pulsed mid-stream at Level=9: next edge gives Level_out=0, WrPtrGray_out=0, Overflow_out=0, Full_out=1, INIT re-entered.
- Random WrReq_in with random legal read-pointer walk: scoreboard confirms no accept while Full_out, and Level_out is never below the true occupancy.
